// File: rtl/vc_pop_scheduler_if.sv
// Link-side bundle between the VC pop scheduler and its FIFOs.
// It carries the occupancy inputs, the pop/select outputs and the counter read port.
interface vc_pop_scheduler_if #(
   parameter int OCC_W = 4,
   parameter int CNT_W = 5
);
   logic [4*OCC_W-1:0] occ_in;
   logic [OCC_W-1:0]   occ_out;
   logic [3:0]         pop_out;
   logic [1:0]         sel;
   logic               req;
   logic [1:0]         idx;
   logic [CNT_W-1:0]   contador;
   logic               valid;

   modport master (
      input  occ_in, occ_out, req, idx,
      output pop_out, sel, contador, valid
   );

   modport slave (
      output occ_in, occ_out, req, idx,
      input  pop_out, sel, contador, valid
   );
endinterface

// File: rtl/vc_pop_scheduler.sv
// Pop-side round-robin scheduler for four PCIe virtual-channel FIFOs with
// hysteresis back-pressure. Define ARB_URGENT_EN to serve above-threshold channels first.
module vc_pop_scheduler #(
   parameter int CNT_W = 5,
   parameter int OCC_W = 4,
   parameter int THR_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   input  logic [THR_W-1:0]    Umbral_bajo,
   input  logic [THR_W-1:0]    Umbral_alto,
   vc_pop_scheduler_if.master  bus,
   output logic [4:0]          state
);

   typedef enum logic [4:0] {
      S_RESET  = 5'b00001,
      S_INIT   = 5'b00010,
      S_IDLE   = 5'b00100,
      S_ACTIVE = 5'b01000,
      S_PAUSE  = 5'b10000
   } state_t;

   state_t cur_state, next_state;

   logic [THR_W-1:0] thr_lo, thr_hi;
   logic [1:0]       rr_ptr;
   logic [CNT_W-1:0] cnt [4];

   logic [OCC_W-1:0] occ_ch [4];
   logic [3:0]       nonempty, cand;
   logic             any_nonempty, below_hi, at_or_below_lo;
   logic             grant_valid, pop_en;
   logic [1:0]       grant, probe;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         occ_ch[i]   = bus.occ_in[i*OCC_W +: OCC_W];
         nonempty[i] = (occ_ch[i] != '0);
      end
      any_nonempty   = |nonempty;
      below_hi       = bus.occ_out <  OCC_W'(thr_hi);
      at_or_below_lo = bus.occ_out <= OCC_W'(thr_lo);
   end

`ifdef ARB_URGENT_EN
   logic [3:0] urgent;

   always_comb begin
      for (int i = 0; i < 4; i++)
         urgent[i] = (occ_ch[i] >= OCC_W'(thr_hi)) && nonempty[i];
      cand = (urgent != 4'b0000) ? urgent : nonempty;
   end
`else
   always_comb cand = nonempty;
`endif

   // First candidate found walking forward from the round-robin pointer.
   always_comb begin
      grant       = 2'd0;
      grant_valid = 1'b0;
      probe       = 2'd0;
      for (int k = 0; k < 4; k++) begin
         probe = rr_ptr + 2'(k);
         if (!grant_valid && cand[probe]) begin
            grant       = probe;
            grant_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_state <= S_RESET;
      else       cur_state <= next_state;
   end

   always_comb begin
      next_state = cur_state;
      pop_en     = 1'b0;
      case (cur_state)
         S_RESET: next_state = S_INIT;
         S_INIT:  if (!init) next_state = S_IDLE;
         S_IDLE: begin
            if (init)                          next_state = S_INIT;
            else if (any_nonempty && below_hi) next_state = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (init)               next_state = S_INIT;
            else if (!below_hi)     next_state = S_PAUSE;
            else if (!any_nonempty) next_state = S_IDLE;
            else                    pop_en     = grant_valid;
         end
         S_PAUSE: begin
            if (init)                next_state = S_INIT;
            else if (at_or_below_lo) next_state = any_nonempty ? S_ACTIVE : S_IDLE;
         end
         default: next_state = S_RESET;
      endcase
   end

   assign bus.pop_out = pop_en ? (4'b0001 << grant) : 4'b0000;
   assign state       = cur_state;

   // Counters clear on every entry into INIT; a read reports the pre-edge value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         thr_lo       <= '0;
         thr_hi       <= '0;
         rr_ptr       <= 2'd0;
         bus.sel      <= 2'd0;
         bus.contador <= '0;
         bus.valid    <= 1'b0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         if (cur_state == S_INIT) begin
            thr_lo <= Umbral_bajo;
            thr_hi <= Umbral_alto;
         end
         if (next_state == S_INIT && cur_state != S_INIT) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
         end else if (pop_en) begin
            rr_ptr  <= grant + 2'd1;
            bus.sel <= grant;
            if (cnt[grant] != {CNT_W{1'b1}}) cnt[grant] <= cnt[grant] + CNT_W'(1);
         end
         bus.valid <= bus.req && (cur_state != S_RESET);
         if (bus.req && cur_state != S_RESET) bus.contador <= cnt[bus.idx];
      end
   end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Scoreboard bench for vc_pop_scheduler: expected grants and counter reads are queued
// by the stimulus and consumed by a monitor whenever the DUT pops or flags valid.
module tb_vc_pop_scheduler;

   logic       clk;
   logic       reset;
   logic       init;
   logic [2:0] bajo, alto;
   logic [4:0] state;

   vc_pop_scheduler_if bus ();

   vc_pop_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .init       (init),
      .Umbral_bajo(bajo),
      .Umbral_alto(alto),
      .bus        (bus),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_fail;
   int occ [4];
   int exp_grant [$];
   int exp_cnt [$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, exp);
      end
   endtask

   task automatic driveOcc();
      for (int i = 0; i < 4; i++) bus.occ_in[i*4 +: 4] = 4'(occ[i]);
   endtask

   // Models the input FIFOs: a pop seen at an edge lowers occupancy just after it.
   task automatic tick();
      logic [3:0] p;
      @(negedge clk);
      p = bus.pop_out;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (p[i] && occ[i] > 0) occ[i]--;
      driveOcc();
   endtask

   task automatic drainAll();
      int k;
      k = 0;
      while (k < 200 && !(state == 5'b00100 && occ[0] == 0 && occ[1] == 0 &&
                          occ[2] == 0 && occ[3] == 0)) begin
         tick();
         k++;
      end
      check("drain_done", int'(k < 200), 1);
   endtask

   task automatic applyStimulus(input int ch, input int n);
      for (int i = 0; i < n; i++) exp_grant.push_back(ch);
   endtask

   task automatic monitorLoop();
      int e;
      logic [3:0] onehot;
      forever begin
         @(negedge clk);
         if (bus.pop_out != 4'b0000) begin
            if (exp_grant.size() == 0) begin
               check("unexpected_pop", int'(bus.pop_out), 0);
            end else begin
               e = exp_grant.pop_front();
               onehot = 4'b0001 << e;
               check("grant", int'(bus.pop_out), int'(onehot));
            end
         end
         if (bus.valid) begin
            if (exp_cnt.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = exp_cnt.pop_front();
               check("contador", int'(bus.contador), e);
            end
         end
      end
   endtask

   task automatic initPulse();
      init = 1'b1;
      tick();
      check("init_entry", int'(state), 2);
      init = 1'b0;
      tick();
      check("init_exit", int'(state), 4);
   endtask

   task automatic checkOutput(input int idx_v, input int expv);
      bus.req = 1'b1;
      bus.idx = 2'(idx_v);
      exp_cnt.push_back(expv);
      tick();
      bus.req = 1'b0;
      check("read_valid_hi", int'(bus.valid), 1);
      tick();
      check("read_valid_lo", int'(bus.valid), 0);
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b0;
      init = 1'b1;
      bajo = 3'd2;
      alto = 3'd6;
      bus.occ_out = 4'd0;
      bus.req = 1'b0;
      bus.idx = 2'd0;
      for (int i = 0; i < 4; i++) occ[i] = 0;
      driveOcc();
      fork
         monitorLoop();
      join_none
      #1 reset = 1'b1;
      tick();
      tick();
      check("reset_state", int'(state), 1);
      check("reset_pop", int'(bus.pop_out), 0);
      check("reset_sel", int'(bus.sel), 0);
      check("reset_valid", int'(bus.valid), 0);
      check("reset_contador", int'(bus.contador), 0);

      reset = 1'b0;
      tick();
      check("to_init", int'(state), 2);
      check("init_pop", int'(bus.pop_out), 0);
      tick();
      check("hold_init", int'(state), 2);
      init = 1'b0;
      tick();
      check("to_idle", int'(state), 4);
      check("idle_pop", int'(bus.pop_out), 0);

      // Plain round-robin over four equally filled channels.
      for (int i = 0; i < 4; i++) occ[i] = 2;
      driveOcc();
      for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) applyStimulus(c, 1);
      drainAll();
      check("rr_end_state", int'(state), 4);
      check("rr_last_sel", int'(bus.sel), 3);

      // Back-to-back reads with req held high.
      bus.req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.idx = 2'(i);
         exp_cnt.push_back(2);
         tick();
      end
      bus.req = 1'b0;
      tick();
      check("burst_valid_lo", int'(bus.valid), 0);

      // Urgent channel 2 versus ordinary channel 0, pointer at 0.
      occ[0] = 1;
      occ[2] = 7;
      driveOcc();
`ifdef ARB_URGENT_EN
      applyStimulus(2, 2);
      applyStimulus(0, 1);
      applyStimulus(2, 5);
`else
      applyStimulus(0, 1);
      applyStimulus(2, 7);
`endif
      drainAll();

      // Hysteresis: pause at alto, hold above bajo, resume at bajo.
      occ[3] = 4;
      driveOcc();
      tick();
      check("pause_pre_active", int'(state), 8);
      bus.occ_out = 4'd6;
      #1;
      check("pause_gate_pop", int'(bus.pop_out), 0);
      tick();
      check("pause_enter", int'(state), 16);
      check("pause_pop", int'(bus.pop_out), 0);
      bus.occ_out = 4'd3;
      tick();
      check("pause_hold", int'(state), 16);
      bus.occ_out = 4'd2;
      applyStimulus(3, 4);
      tick();
      check("pause_resume", int'(state), 8);
      drainAll();
      bus.occ_out = 4'd0;

      // Three pops on channel 1 after counters are cleared.
      initPulse();
      occ[1] = 3;
      driveOcc();
      applyStimulus(1, 3);
      drainAll();
      checkOutput(1, 3);
      checkOutput(0, 0);

      // Counter saturation on channel 0 (35 pops, 5-bit counter).
      initPulse();
      for (int r = 0; r < 7; r++) begin
         occ[0] = 5;
         driveOcc();
         applyStimulus(0, 5);
         drainAll();
      end
      checkOutput(0, 31);

      // Zero high threshold: never allowed to pop.
      alto = 3'd0;
      bajo = 3'd0;
      initPulse();
      occ[2] = 3;
      driveOcc();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("zero_thr_pop", int'(bus.pop_out), 0);
         check("zero_thr_not_active", int'(state == 5'b01000), 0);
      end
      occ[2] = 0;
      driveOcc();

      // Asynchronous reset in the middle of ACTIVE.
      alto = 3'd6;
      bajo = 3'd2;
      initPulse();
      occ[0] = 4;
      driveOcc();
      tick();
      applyStimulus(0, 1);
      tick();
      check("pre_reset_pop", int'(bus.pop_out), 1);
      reset = 1'b1;
      #1;
      check("async_reset_state", int'(state), 1);
      check("async_reset_pop", int'(bus.pop_out), 0);
      for (int i = 0; i < 4; i++) occ[i] = 0;
      driveOcc();
      tick();
      reset = 1'b0;
      tick();
      check("post_reset_init", int'(state), 2);
      checkOutput(0, 0);

      check("grant_queue_empty", exp_grant.size(), 0);
      check("cnt_queue_empty", exp_cnt.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
